// File: rtl/machine_timer.sv
// machine_timer: memory-mapped RISC-V style mtime/mtimecmp/msip timer with a
// prescaled 64-bit counter and registered single-cycle register access.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module machine_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   req_i,
  input  logic                   we_i,
  input  logic [`ADDR_WIDTH-1:0] addr_i,
  input  logic [`DATA_WIDTH-1:0] wdata_i,
  output logic [`DATA_WIDTH-1:0] rdata_o,
  output logic                   ack_o,
  output logic                   timer_interrupt_o,
  output logic                   software_interrupt_o
);
  localparam logic [4:0] A_MSIP = 5'h00;
  localparam logic [4:0] A_CMPL = 5'h04;
  localparam logic [4:0] A_CMPH = 5'h08;
  localparam logic [4:0] A_MTL  = 5'h0C;
  localparam logic [4:0] A_MTH  = 5'h10;
  localparam logic [4:0] A_CTRL = 5'h14;
  localparam logic [15:0] P_LAST = 16'(PRESCALE - 1);
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d, mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q, rdata_d, rd_val;
  logic        msip_q, msip_d, ctrl_q, ctrl_d, ack_q, ack_d, tint_q, tint_d;
  logic        wr, tick;
  logic [4:0]  a;
  logic        addr_unused;
  assign a = addr_i[4:0];
  assign addr_unused = ^addr_i[`ADDR_WIDTH-1:5];
  always_comb begin
    wr = req_i && we_i;
    tick = ctrl_q && presc_q == P_LAST;
    presc_d = (wr && a == A_CTRL) ? 16'd0 : tick ? 16'd0 : ctrl_q ? presc_q + 16'd1 : presc_q;
    // A half-write wins over a coincident increment; the other half keeps its old value.
    mtime_d = (wr && a == A_MTL) ? {mtime_q[63:32], wdata_i} :
              (wr && a == A_MTH) ? {wdata_i, mtime_q[31:0]} :
              tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = (wr && a == A_CMPL) ? {mtimecmp_q[63:32], wdata_i} :
                 (wr && a == A_CMPH) ? {wdata_i, mtimecmp_q[31:0]} : mtimecmp_q;
    msip_d = (wr && a == A_MSIP) ? wdata_i[0] : msip_q;
    ctrl_d = (wr && a == A_CTRL) ? wdata_i[0] : ctrl_q;
    tint_d = mtime_q >= mtimecmp_q;
    ack_d = req_i;
    case (a)
      A_MSIP:  rd_val = {31'd0, msip_q};
      A_CMPL:  rd_val = mtimecmp_q[31:0];
      A_CMPH:  rd_val = mtimecmp_q[63:32];
      A_MTL:   rd_val = mtime_q[31:0];
      A_MTH:   rd_val = mtime_q[63:32];
      A_CTRL:  rd_val = {31'd0, ctrl_q};
      default: rd_val = 32'd0;
    endcase
    rdata_d = (req_i && !we_i) ? rd_val : 32'd0;
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      presc_q    <= '0;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      msip_q     <= 1'b0;
      ctrl_q     <= 1'b1;
      ack_q      <= 1'b0;
      rdata_q    <= '0;
      tint_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      msip_q     <= msip_d;
      ctrl_q     <= ctrl_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      tint_q     <= tint_d;
    end
  end
  assign rdata_o = rdata_q;
  assign ack_o = ack_q;
  assign timer_interrupt_o = tint_q;
  assign software_interrupt_o = msip_q;
endmodule

// File: doc/machine_timer.md
MACHINE_TIMER -- requirements
Module: machine_timer

Interface
REQ-001 The block SHALL have parameter PRESCALE, default 1, meaning the number of clk_i cycles per mtime increment (legal range 1..65535).
REQ-002 The block SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-004 The block SHALL have port req_i  input  1  register-access request, one cycle per access.
REQ-005 The block SHALL have port we_i  input  1  1 = write, 0 = read; sampled only when req_i=1.
REQ-006 The block SHALL have port addr_i  input  `ADDR_WIDTH  byte address; only bits [4:0] are decoded.
REQ-007 The block SHALL have port wdata_i  input  `DATA_WIDTH  write data.
REQ-008 The block SHALL have port rdata_o  output  `DATA_WIDTH  read data, valid while ack_o=1.
REQ-009 The block SHALL have port ack_o  output  1  single-cycle access completion.
REQ-010 The block SHALL have port timer_interrupt_o  output  1  machine timer interrupt level, to the interrupt unit's timer_interrupt_i.
REQ-011 The block SHALL have port software_interrupt_o  output  1  machine software interrupt level (msip bit 0).

Function
REQ-012 The register map SHALL be: 0x00 msip (bit 0 only, others read 0), 0x04 mtimecmp[31:0], 0x08 mtimecmp[63:32], 0x0C mtime[31:0], 0x10 mtime[63:32], 0x14 ctrl (bit 0 = count enable, others read 0).
REQ-013 Accesses to any other offset SHALL ignore writes, return 0 on reads, and still assert ack_o.
REQ-014 A request accepted at cycle N SHALL produce ack_o=1 for exactly cycle N+1; reads SHALL present rdata_o in cycle N+1 with the register value as of cycle N (before that cycle's increment or write).
REQ-015 rdata_o SHALL be 0 whenever ack_o=0.
REQ-016 A 5-bit-decoded write SHALL take effect at the end of cycle N, visible to a read issued at N+1.
REQ-017 A 16-bit prescale counter SHALL count 0..PRESCALE-1 while ctrl[0]=1 and wrap to 0; mtime SHALL increment by 1 in the cycle the prescale counter equals PRESCALE-1.
REQ-018 When ctrl[0]=0, both the prescale counter and mtime SHALL hold their values.
REQ-019 Writing ctrl SHALL clear the prescale counter to 0.
REQ-020 mtime SHALL be a 64-bit unsigned counter wrapping from 0xFFFF_FFFF_FFFF_FFFF to 0.
REQ-021 A carry from mtime[31:0] SHALL propagate into mtime[63:32] in the same cycle.
REQ-022 On a write to a mtime half coinciding with an increment, the written half SHALL take wdata_i and the other half SHALL keep its pre-increment value (write wins, no carry applied).
REQ-023 timer_interrupt_o SHALL be registered: asserted in cycle N+1 when unsigned mtime >= mtimecmp at cycle N, and deasserted likewise; it is a level and SHALL remain high until the compare fails.
REQ-024 software_interrupt_o SHALL equal the registered msip[0].

Reset
REQ-025 While rst_n_i=0 the block SHALL asynchronously reset: mtime=0, prescale counter=0, mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, ctrl=0x1, ack_o=0, rdata_o=0, timer_interrupt_o=0, software_interrupt_o=0.
REQ-026 A request in flight when reset asserts SHALL be dropped: no ack_o after reset release.
REQ-027 Counting SHALL resume on the first rising clk_i edge after rst_n_i deasserts.

Verification
REQ-028 The bench SHALL cover: reset with PRESCALE=1, then read 0x0C at cycle 5 after release -> ack_o at cycle 6, rdata_o=5, timer_interrupt_o=0.
REQ-029 The bench SHALL cover: write mtimecmp=0x0000_0000_0000_0010 (hi then lo), PRESCALE=1 -> timer_interrupt_o rises the cycle after mtime reaches 0x10; then write mtimecmp lo=0xFFFF_FFFF -> timer_interrupt_o falls the following cycle.
REQ-030 The bench SHALL cover: write mtime lo=0xFFFF_FFFF, hi=0x0000_0001 with ctrl=1 -> next increment gives hi=0x0000_0002, lo=0; then write both halves =0xFFFF_FFFF -> next increment wraps mtime to 0.
REQ-031 The bench SHALL cover: PRESCALE=4, ctrl written 1 at cycle 0 -> mtime increments at cycles 3, 7, 11; writing ctrl=0 freezes mtime across 20 cycles.
REQ-032 The bench SHALL cover: write msip=0xFFFF_FFFF -> software_interrupt_o=1 next cycle and reading 0x00 returns 0x1; read 0x18 -> ack_o=1, rdata_o=0.
REQ-033 The bench SHALL cover: assert rst_n_i low mid-read -> no ack_o after release and all outputs at their REQ-025 values.
